// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe
//   Three-stage Sobel gradient unit with a valid/ready stream interface.
//   It computes Gx and Gy for a 3x3 window and outputs |Gx|, |Gy|, their
//   sign bits and the L1 magnitude |Gx|+|Gy|. It accepts one window per
//   cycle, and each window takes 3 cycles from input to output.
//
//   Optional feature: define SOBEL_MAG_CLAMP_EN to saturate mag to
//   2^PIXEL_W-1. When the macro is defined, the result can be written
//   directly as an output pixel.
//
//   Ports
//     clk, rst            single clock, synchronous active-high reset
//     window[9*PIXEL_W]   pixels w0..w8, row-major, w0 in the LSBs
//     in_valid/in_ready   input handshake (in_ready = advance && !rst)
//     gx_abs, gy_abs      |Gx|, |Gy|            (GRAD_W bits)
//     gx_neg, gy_neg      Gx < 0, Gy < 0
//     mag                 |Gx| + |Gy|           (MAG_W bits)
//     out_valid/out_ready output handshake

// Per-axis datapath for S1 and S2.
// S1 registers the weighted sum of the positive taps and the weighted sum
// of the negative taps. The middle tap of each group has weight 2.
// S2 registers the absolute value and sign of the difference.
module sobel_axis #(
    parameter int PIXEL_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    input  logic [2:0][PIXEL_W-1:0]       pos_taps,
    input  logic [2:0][PIXEL_W-1:0]       neg_taps,
    output logic [PIXEL_W+1:0]            abs_q,
    output logic                          neg_q
);
    localparam int SUM_W = PIXEL_W + 2;

    logic [SUM_W-1:0]        pos_sum_d, neg_sum_d;
    logic [SUM_W-1:0]        pos_sum_q, neg_sum_q;
    logic signed [SUM_W:0]   diff;
    logic [SUM_W-1:0]        abs_d;

    // Each sum is at most 4*(2^PIXEL_W-1), so it fits in PIXEL_W+2 bits.
    assign pos_sum_d = {2'b00, pos_taps[0]} + {1'b0, pos_taps[1], 1'b0} + {2'b00, pos_taps[2]};
    assign neg_sum_d = {2'b00, neg_taps[0]} + {1'b0, neg_taps[1], 1'b0} + {2'b00, neg_taps[2]};

    assign diff  = signed'({1'b0, pos_sum_q}) - signed'({1'b0, neg_sum_q});
    // The magnitude is bounded by 4*(2^PIXEL_W-1). Truncating to SUM_W bits
    // therefore loses nothing.
    assign abs_d = SUM_W'(diff[SUM_W] ? -diff : diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_sum_q <= '0;
            neg_sum_q <= '0;
            abs_q     <= '0;
            neg_q     <= 1'b0;
        end else if (advance) begin
            pos_sum_q <= pos_sum_d;
            neg_sum_q <= neg_sum_d;
            abs_q     <= abs_d;
            neg_q     <= diff[SUM_W];
        end
    end
endmodule

module sobel_gradient_pipe #(
    parameter int PIXEL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9*PIXEL_W-1:0]   window,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PIXEL_W+1:0]     gx_abs,
    output logic [PIXEL_W+1:0]     gy_abs,
    output logic                   gx_neg,
    output logic                   gy_neg,
    output logic [PIXEL_W+2:0]     mag,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int GRAD_W   = PIXEL_W + 2;
    localparam int MAG_W    = PIXEL_W + 3;
    localparam int STAGES   = 3;
    localparam int NUM_AXES = 2;   // 0 = x, 1 = y

    logic [8:0][PIXEL_W-1:0]                 w;
    logic [NUM_AXES-1:0][2:0][PIXEL_W-1:0]   pos_taps, neg_taps;
    logic [NUM_AXES-1:0][GRAD_W-1:0]         abs_s2;
    logic [NUM_AXES-1:0]                     neg_s2;
    logic [STAGES-1:0]                       vld_pipe;
    logic                                    advance, accept;
    logic [MAG_W-1:0]                        mag_sum, mag_d;
    logic                                    unused_center;

    assign w = window;
    // The center pixel has zero weight in both kernels.
    assign unused_center = ^w[4];

    // Tap order is {weight-1, weight-2, weight-1}.
    // The middle element gets weight 2.
    assign pos_taps[0] = {w[8], w[5], w[2]};
    assign neg_taps[0] = {w[6], w[3], w[0]};
    assign pos_taps[1] = {w[8], w[7], w[6]};
    assign neg_taps[1] = {w[2], w[1], w[0]};

    // Global stall: the whole pipe freezes, including bubbles, whenever
    // the output slot is occupied and downstream is not taking it.
    assign out_valid = vld_pipe[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rst;
    assign accept    = in_valid && in_ready;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        sobel_axis #(.PIXEL_W(PIXEL_W)) u_axis (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .pos_taps (pos_taps[a]),
            .neg_taps (neg_taps[a]),
            .abs_q    (abs_s2[a]),
            .neg_q    (neg_s2[a])
        );
    end

    // The sum is at most 8*(2^PIXEL_W-1), which fits in MAG_W bits.
    assign mag_sum = MAG_W'(abs_s2[0]) + MAG_W'(abs_s2[1]);

`ifdef SOBEL_MAG_CLAMP_EN
    localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIXEL_W) - 1);
    assign mag_d = (mag_sum > PIX_MAX) ? PIX_MAX : mag_sum;
`else
    assign mag_d = mag_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            gx_abs   <= '0;
            gy_abs   <= '0;
            gx_neg   <= 1'b0;
            gy_neg   <= 1'b0;
            mag      <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-2:0], accept};
            gx_abs   <= abs_s2[0];
            gy_abs   <= abs_s2[1];
            gx_neg   <= neg_s2[0];
            gy_neg   <= neg_s2[1];
            mag      <= mag_d;
        end
    end
endmodule

// File: doc/sobel_gradient_pipe.md
# sobel_gradient_pipe

Pipelined, parametrised Sobel gradient unit that computes both horizontal (Gx) and vertical (Gy) gradients of a 3x3 pixel window, their absolute values and sign bits, and the L1 magnitude |Gx|+|Gy|. It sits between the window buffer and the output pixel writer in the edge-detection datapath. It replaces the single-axis combinational gradient calculators with one valid/ready-streamed block: throughput of one window per cycle and fixed 3-cycle latency.

## Interface
- PIXEL_W, 8, bits per pixel (unsigned); legal range 4..16
- GRAD_W, PIXEL_W+2, derived localparam; width of |Gx| and |Gy| (max 4*(2^PIXEL_W-1))
- MAG_W, PIXEL_W+3, derived localparam; width of magnitude
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- window  in  9*PIXEL_W  pixels w0..w8, row-major (w0 top-left, w8 bottom-right); w0 in LSBs
- in_valid  in  1  window valid
- in_ready  out  1  unit accepts window this cycle
- gx_abs  out  GRAD_W  |Gx|
- gy_abs  out  GRAD_W  |Gy|
- gx_neg  out  1  Gx < 0
- gy_neg  out  1  Gy < 0
- mag  out  MAG_W  gx_abs + gy_abs (clamped if SOBEL_MAG_CLAMP_EN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

## Operation
- Gx = (w2 + 2*w5 + w8) - (w0 + 2*w3 + w6); Gy = (w6 + 2*w7 + w8) - (w0 + 2*w1 + w2).
- Stage 1 (S1): register the four weighted sums, unsigned, PIXEL_W+2 bits each. No overflow is possible.
- Stage 2 (S2): signed subtraction at PIXEL_W+3 bits; register the absolute values and sign bits. Zero yields neg=0.
- Stage 3 (S3): register mag = gx_abs + gy_abs, MAG_W bits, no wrap. Max 8*(2^PIXEL_W-1).
- Each stage has a valid bit. Bubbles propagate as invalid slots.
- Global stall: advance = !out_valid || out_ready.
  - in_ready = advance && !rst.
  - When advance=0, all stage registers, including bubbles and valid bits, hold.
  - Output ports hold their value while stalled.
- A window is accepted only when in_valid && in_ready. When in_valid=0 and advance=1, S1 valid loads 0.
- Data outputs are undefined-but-stable while out_valid=0. The implementation keeps the S3 data registers and does not clear them.

## Timing
- Reset value of every registered output is 0: gx_abs, gy_abs, gx_neg, gy_neg, mag, out_valid, and all stage valid bits.
- in_ready is 0 while rst=1, and 1 in the first cycle after rst deasserts.
- Latency: window accepted at edge T produces out_valid=1 after edge T+3, with no stalls.
- Throughput: 1 result per cycle while out_ready=1.
- Each stall cycle with out_valid=1 and out_ready=0 adds exactly one cycle to every in-flight item. No data is lost or duplicated.
- Handshake rules:
  - Output transfer occurs when out_valid && out_ready.
  - out_valid never drops without a transfer, except on reset.
  - in_ready may depend combinationally on out_ready. There is no other combinational input-to-output path.
- Reset mid-stream: all in-flight items are discarded and out_valid=0 after the reset edge. A window presented on the reset cycle is not accepted.
- Simultaneous output transfer and input accept in one cycle is legal and is the steady state.

## Configuration
- SOBEL_MAG_CLAMP_EN defined:
  - S3 saturates mag to 2^PIXEL_W-1 (255 at default).
  - Upper MAG_W-PIXEL_W bits of mag are always 0.
  - Result is directly writable as an output pixel.
- Undefined: mag is the full unclamped L1 sum.
- gx_abs, gy_abs and the sign bits are identical in both builds.

## Test plan
- Window {50,255,250,100,0,200,100,255,255}, out_ready=1 -> 3 cycles later: gx_abs=555, gx_neg=0, gy_abs=55, gy_neg=0. mag=610 unclamped, 255 with SOBEL_MAG_CLAMP_EN.
- Window {40,255,32,255,255,100,0,255,1} -> gx_abs=317, gx_neg=1, gy_abs=71, gy_neg=1. mag=388 unclamped, 255 clamped.
- All 255, then {0,0,0,0,0,0,255,255,255} on consecutive cycles -> back-to-back results:
  - first: gx_abs=0, gy_abs=0, neg=0, mag=0
  - second: gy_abs=1020, gy_neg=0, gx_abs=0, mag=1020 (255 clamped)
- Stream 6 windows {k,0,0,0,0,0,0,0,0} with k=1..6; hold out_ready=0 for 4 cycles after the first out_valid:
  - in_ready=0 and outputs frozen during the stall
  - then 6 results gx_abs=k, gx_neg=1, gy_abs=k, gy_neg=1, mag=2k, in order, none dropped or duplicated
- Assert rst for 1 cycle with 3 items in flight -> out_valid=0 and all outputs 0 next cycle; in_ready=1 the cycle after rst deasserts; a following window gives a correct result at latency 3.
- in_valid toggling 1,0,1,0 -> out_valid pattern 1,0,1,0, starting 3 cycles after the first accept.
